ex_stage: RTL and testbench

- Execute stage directly downstream of the ID/EX pipeline register.
- Contains operand forwarding muxes, the ALU, a 32-iteration shift-add multiplier, and the EX/MEM pipeline register.
- Drives stall_o to the hazard unit, which freezes PC, IF/ID and ID/EX while a multiply is in progress.
- Outputs feed the MEM stage and EX-side forwarding.

---
 rtl/ex_pkg.sv | 66 ++++++
 rtl/ex_stage_if.sv | 43 ++++
 rtl/ex_mul_seq.sv | 72 +++++++
 rtl/ex_stage.sv | 136 +++++++++++++
 tb/tb_ex_stage.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_pkg                                                      |
// | Description : Shared encodings for the execute stage: ALUOp/funct codes,  |
// |               control-field bit indices, ALU and multiplier FSM enums.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ex_pkg;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_rtype = 2'b10;
    localparam logic [1:0] c_aluop_addi  = 2'b11;

    localparam logic [5:0] c_funct_add = 6'b100000;
    localparam logic [5:0] c_funct_sub = 6'b100010;
    localparam logic [5:0] c_funct_and = 6'b100100;
    localparam logic [5:0] c_funct_or  = 6'b100101;
    localparam logic [5:0] c_funct_mul = 6'b011000;

    localparam int c_wb_regwrite = 1;
    localparam int c_wb_memtoreg = 0;
    localparam int c_m_memread   = 1;
    localparam int c_m_memwrite  = 0;
    localparam int c_ex_regdst   = 3;
    localparam int c_ex_aluop_hi = 2;
    localparam int c_ex_aluop_lo = 1;
    localparam int c_ex_alusrc   = 0;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_MUL,
        ALU_NONE
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mul_state_e;

    function automatic alu_op_e decode_alu(input logic [1:0] aluop, input logic [5:0] funct);
        alu_op_e op;
        op = ALU_NONE;
        case (aluop)
            c_aluop_add, c_aluop_addi: op = ALU_ADD;
            c_aluop_sub:               op = ALU_SUB;
            default: begin
                case (funct)
                    c_funct_add: op = ALU_ADD;
                    c_funct_sub: op = ALU_SUB;
                    c_funct_and: op = ALU_AND;
                    c_funct_or:  op = ALU_OR;
                    c_funct_mul: op = ALU_MUL;
                    default:     op = ALU_NONE;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_stage_if                                                 |
// | Description : ID/EX inputs, MEM/WB forwarding inputs and EX/MEM outputs    |
// |               of the execute stage.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [1:0]        wb_i;
    logic [1:0]        m_i;
    logic [3:0]        ex_i;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic [DATA_W-1:0] signextend_i;
    logic [REG_AW-1:0] rs_i;
    logic [REG_AW-1:0] rt_i;
    logic [REG_AW-1:0] rd_i;
    logic              memwb_regwrite_i;
    logic [REG_AW-1:0] memwb_rd_i;
    logic [DATA_W-1:0] memwb_data_i;
    logic [1:0]        wb_o;
    logic [1:0]        m_o;
    logic [DATA_W-1:0] alu_result_o;
    logic [DATA_W-1:0] wdata_o;
    logic [REG_AW-1:0] rd_o;
    logic              stall_o;

    modport slave (
        input  wb_i, m_i, ex_i, data1_i, data2_i, signextend_i, rs_i, rt_i, rd_i,
        input  memwb_regwrite_i, memwb_rd_i, memwb_data_i,
        output wb_o, m_o, alu_result_o, wdata_o, rd_o, stall_o
    );

    modport master (
        output wb_i, m_i, ex_i, data1_i, data2_i, signextend_i, rs_i, rt_i, rd_i,
        output memwb_regwrite_i, memwb_rd_i, memwb_data_i,
        input  wb_o, m_o, alu_result_o, wdata_o, rd_o, stall_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_mul_seq                                                  |
// | Description : Iterative shift-add multiplier (low word), one bit per cycle.|
// |               Instantiated only when EX_STAGE_MUL_EN is defined.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ex_mul_seq
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              start_i,
    input  wire logic [DATA_W-1:0] op_a_i,
    input  wire logic [DATA_W-1:0] op_b_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_W-1:0]      product_o
);
    localparam int                 c_cnt_w    = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W - 1);

    mul_state_e          r_state;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [DATA_W-1:0]   r_prod;
    logic [c_cnt_w-1:0]  r_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_mcand  <= op_a_i;
                        r_mplier <= op_b_i;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Busy asserts in the issue cycle so upstream freezes before the first edge.
    assign busy_o    = rst_i & (((r_state == ST_IDLE) & start_i) | (r_state == ST_BUSY));
    assign done_o    = (r_state == ST_DONE);
    assign product_o = r_prod;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_stage                                                    |
// | Description : Execute stage: forwarding, ALU, optional sequential multiply |
// |               (macro EX_STAGE_MUL_EN) and the EX/MEM pipeline register.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    ex_stage_if.slave  bus
);
    logic [1:0]        r_wb;
    logic [1:0]        r_m;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_AW-1:0] r_rd;
    logic [1:0]        r_hold_wb;
    logic [1:0]        r_hold_m;
    logic [REG_AW-1:0] r_hold_rd;
    logic              r_stall_q;

    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_op2;
    logic [DATA_W-1:0] w_alu_res;
    logic [REG_AW-1:0] w_dest;
    alu_op_e           w_op;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_product;

    // EX/MEM result wins over MEM/WB: it is the younger producer.
    always_comb begin
        w_fwd_a = bus.data1_i;
        if (r_wb[c_wb_regwrite] && (r_rd != '0) && (r_rd == bus.rs_i)) begin
            w_fwd_a = r_alu;
        end else if (bus.memwb_regwrite_i && (bus.memwb_rd_i != '0) && (bus.memwb_rd_i == bus.rs_i)) begin
            w_fwd_a = bus.memwb_data_i;
        end
    end

    always_comb begin
        w_fwd_b = bus.data2_i;
        if (r_wb[c_wb_regwrite] && (r_rd != '0) && (r_rd == bus.rt_i)) begin
            w_fwd_b = r_alu;
        end else if (bus.memwb_regwrite_i && (bus.memwb_rd_i != '0) && (bus.memwb_rd_i == bus.rt_i)) begin
            w_fwd_b = bus.memwb_data_i;
        end
    end

    assign w_op2  = bus.ex_i[c_ex_alusrc] ? bus.signextend_i : w_fwd_b;
    assign w_dest = bus.ex_i[c_ex_regdst] ? bus.rd_i : bus.rt_i;
    assign w_op   = decode_alu(bus.ex_i[c_ex_aluop_hi:c_ex_aluop_lo], bus.signextend_i[5:0]);

    always_comb begin
        w_alu_res = '0;
        case (w_op)
            ALU_ADD: w_alu_res = w_fwd_a + w_op2;
            ALU_SUB: w_alu_res = w_fwd_a - w_op2;
            ALU_AND: w_alu_res = w_fwd_a & w_op2;
            ALU_OR:  w_alu_res = w_fwd_a | w_op2;
            default: w_alu_res = '0;
        endcase
    end

`ifdef EX_STAGE_MUL_EN
    ex_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (w_op == ALU_MUL),
        .op_a_i    (w_fwd_a),
        .op_b_i    (w_fwd_b),
        .busy_o    (w_mul_busy),
        .done_o    (w_mul_done),
        .product_o (w_product)
    );
`else
    assign w_mul_busy = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_product  = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wb      <= '0;
            r_m       <= '0;
            r_alu     <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_hold_wb <= '0;
            r_hold_m  <= '0;
            r_hold_rd <= '0;
            r_stall_q <= 1'b0;
        end else begin
            r_stall_q <= w_mul_busy;
            // First stalled cycle is the issue cycle of the multiply.
            if (w_mul_busy && !r_stall_q) begin
                r_hold_wb <= bus.wb_i;
                r_hold_m  <= bus.m_i;
                r_hold_rd <= w_dest;
            end
            if (w_mul_busy) begin
                r_wb <= '0;
                r_m  <= '0;
            end else if (w_mul_done) begin
                r_wb  <= r_hold_wb;
                r_m   <= r_hold_m;
                r_rd  <= r_hold_rd;
                r_alu <= w_product;
            end else begin
                r_wb    <= bus.wb_i;
                r_m     <= bus.m_i;
                r_alu   <= w_alu_res;
                r_wdata <= w_fwd_b;
                r_rd    <= w_dest;
            end
        end
    end

    assign bus.wb_o         = r_wb;
    assign bus.m_o          = r_m;
    assign bus.alu_result_o = r_alu;
    assign bus.wdata_o      = r_wdata;
    assign bus.rd_o         = r_rd;
    assign bus.stall_o      = w_mul_busy;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ex_stage                                                 |
// | Description : Directed vectors for ex_stage; multiply expectations follow  |
// |               the EX_STAGE_MUL_EN build option.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ex_stage;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus();

    ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [1:0] m, input logic [3:0] ex,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        bus.wb_i         = wb;
        bus.m_i          = m;
        bus.ex_i         = ex;
        bus.data1_i      = d1;
        bus.data2_i      = d2;
        bus.signextend_i = imm;
        bus.rs_i         = rs;
        bus.rt_i         = rt;
        bus.rd_i         = rd;
    endtask

    task automatic set_memwb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        bus.memwb_regwrite_i = we;
        bus.memwb_rd_i       = rd;
        bus.memwb_data_i     = data;
    endtask

    // R-type mul with rs=20, rt=21; mul build holds for 34 edges, else single-cycle zero.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] exp);
        drive(2'b10, 2'b00, 4'b1100, a, b, 32'h18, 5'd20, 5'd21, rd);
        #1;
`ifdef EX_STAGE_MUL_EN
        check_eq({tag, "_stall_issue"}, {31'b0, bus.stall_o}, 32'd1);
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 5)  set_memwb(1'b1, 5'd20, 32'hDEAD_BEEF);
            if (k == 20) set_memwb(1'b0, 5'd0, 32'h0);
            if (k == 1 || k == 16 || k == 32) begin
                check_eq({tag, "_stall_busy"}, {31'b0, bus.stall_o}, 32'd1);
                check_eq({tag, "_wb_bubble"}, {30'b0, bus.wb_o}, 32'd0);
            end
            if (k == 33) begin
                check_eq({tag, "_stall_done"}, {31'b0, bus.stall_o}, 32'd0);
                check_eq({tag, "_wb_done_bubble"}, {30'b0, bus.wb_o}, 32'd0);
            end
        end
        check_eq({tag, "_result"}, bus.alu_result_o, exp);
        check_eq({tag, "_wb"}, {30'b0, bus.wb_o}, 32'd2);
        check_eq({tag, "_rd"}, {27'b0, bus.rd_o}, {27'b0, rd});
`else
        check_eq({tag, "_stall_off"}, {31'b0, bus.stall_o}, 32'd0);
        tick();
        check_eq({tag, "_result_off"}, bus.alu_result_o, 32'd0);
        check_eq({tag, "_wb_off"}, {30'b0, bus.wb_o}, 32'd2);
        check_eq({tag, "_stall_after"}, {31'b0, bus.stall_o}, 32'd0);
        if (exp == 32'hFFFF_FFFF) n_err++;
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        set_memwb(1'b0, 5'd0, 32'h0);
        repeat (2) tick();
        check_eq("rst_alu", bus.alu_result_o, 32'h0);
        check_eq("rst_stall", {31'b0, bus.stall_o}, 32'h0);

        // Some traffic, then reset asserted mid-stream with a mul on the inputs
        rst_n = 1'b1;
        drive(2'b10, 2'b00, 4'b1100, 32'd9, 32'd9, 32'h20, 5'd1, 5'd2, 5'd6);
        tick();
        check_eq("pre_rst_add", bus.alu_result_o, 32'd18);
        drive(2'b10, 2'b00, 4'b1100, 32'd3, 32'd4, 32'h18, 5'd1, 5'd2, 5'd6);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_alu", bus.alu_result_o, 32'h0);
        check_eq("midrst_wb", {30'b0, bus.wb_o}, 32'h0);
        check_eq("midrst_rd", {27'b0, bus.rd_o}, 32'h0);
        check_eq("midrst_stall", {31'b0, bus.stall_o}, 32'h0);
        tick();

        // add r3 = 5 + 7
        drive(2'b10, 2'b00, 4'b1100, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2, 5'd3);
        rst_n = 1'b1;
        tick();
        check_eq("add_result", bus.alu_result_o, 32'd12);
        check_eq("add_rd", {27'b0, bus.rd_o}, 32'd3);
        check_eq("add_wb", {30'b0, bus.wb_o}, 32'd2);

        // Forwarding: EX/MEM r4=100 vs MEM/WB r4=200
        drive(2'b10, 2'b00, 4'b1100, 32'd60, 32'd40, 32'h20, 5'd1, 5'd2, 5'd4);
        tick();
        check_eq("fwd_setup", bus.alu_result_o, 32'd100);
        set_memwb(1'b1, 5'd4, 32'd200);
        drive(2'b10, 2'b00, 4'b1100, 32'd55, 32'd1, 32'h22, 5'd4, 5'd0, 5'd5);
        tick();
        check_eq("fwd_exmem_prio", bus.alu_result_o, 32'd99);
        check_eq("fwd_wdata", bus.wdata_o, 32'd1);
        drive(2'b10, 2'b00, 4'b1100, 32'd0, 32'd0, 32'h20, 5'd4, 5'd4, 5'd6);
        tick();
        check_eq("fwd_memwb_ab", bus.alu_result_o, 32'd400);
        check_eq("fwd_memwb_wdata", bus.wdata_o, 32'd200);

        // rd = 0 never forwards
        set_memwb(1'b1, 5'd0, 32'd200);
        drive(2'b10, 2'b00, 4'b1100, 32'd60, 32'd40, 32'h20, 5'd1, 5'd2, 5'd0);
        tick();
        check_eq("r0_setup_rd", {27'b0, bus.rd_o}, 32'd0);
        drive(2'b10, 2'b00, 4'b1100, 32'd55, 32'd1, 32'h22, 5'd0, 5'd0, 5'd5);
        tick();
        check_eq("fwd_r0_none", bus.alu_result_o, 32'd54);
        set_memwb(1'b0, 5'd0, 32'h0);

        // ALU op coverage
        drive(2'b10, 2'b00, 4'b1100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h24, 5'd1, 5'd2, 5'd6);
        tick();
        check_eq("alu_and", bus.alu_result_o, 32'h00F0_000F);
        drive(2'b10, 2'b00, 4'b1100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h25, 5'd1, 5'd2, 5'd7);
        tick();
        check_eq("alu_or", bus.alu_result_o, 32'hFFF0_0FFF);
        drive(2'b10, 2'b00, 4'b1010, 32'd10, 32'd3, 32'h20, 5'd1, 5'd2, 5'd8);
        tick();
        check_eq("aluop01_sub", bus.alu_result_o, 32'd7);
        drive(2'b00, 2'b10, 4'b0111, 32'h23, 32'h5, 32'h100, 5'd1, 5'd13, 5'd8);
        tick();
        check_eq("aluop11_imm", bus.alu_result_o, 32'h123);
        check_eq("regdst_rt", {27'b0, bus.rd_o}, 32'd13);
        check_eq("m_pass", {30'b0, bus.m_o}, 32'd2);
        drive(2'b10, 2'b00, 4'b1100, 32'd8, 32'd9, 32'h27, 5'd1, 5'd2, 5'd9);
        tick();
        check_eq("funct_unknown", bus.alu_result_o, 32'd0);
        drive(2'b10, 2'b00, 4'b1001, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd1, 5'd2, 5'd9);
        tick();
        check_eq("add_wrap", bus.alu_result_o, 32'd0);

        // Store with rt forwarded from MEM/WB
        set_memwb(1'b1, 5'd2, 32'h0000_CAFE);
        drive(2'b00, 2'b01, 4'b0001, 32'h1000, 32'd0, 32'd4, 5'd1, 5'd2, 5'd0);
        tick();
        check_eq("sw_addr", bus.alu_result_o, 32'h1004);
        check_eq("sw_wdata", bus.wdata_o, 32'h0000_CAFE);
        set_memwb(1'b0, 5'd0, 32'h0);

        // Multiplies, back to back
        run_mul("mul1", 32'h0001_0003, 32'h0000_0010, 5'd9, 32'h0010_0030);
        run_mul("mul_wrap", 32'hFFFF_FFFF, 32'd2, 5'd10, 32'hFFFF_FFFE);

        // Reset while BUSY with counter at 10
        drive(2'b10, 2'b00, 4'b1100, 32'd3, 32'd5, 32'h18, 5'd20, 5'd21, 5'd11);
        repeat (11) tick();
        rst_n = 1'b0;
        #1;
        check_eq("mulrst_stall", {31'b0, bus.stall_o}, 32'd0);
        check_eq("mulrst_alu", bus.alu_result_o, 32'd0);
        check_eq("mulrst_wb", {30'b0, bus.wb_o}, 32'd0);
        check_eq("mulrst_rd", {27'b0, bus.rd_o}, 32'd0);
        drive(2'b10, 2'b00, 4'b0001, 32'd1, 32'd0, 32'd1, 5'd1, 5'd12, 5'd0);
        rst_n = 1'b1;
        #1;
        check_eq("postrst_stall", {31'b0, bus.stall_o}, 32'd0);
        tick();
        check_eq("postrst_add", bus.alu_result_o, 32'd2);
        check_eq("postrst_rd", {27'b0, bus.rd_o}, 32'd12);
        check_eq("postrst_stall2", {31'b0, bus.stall_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
